// File: rtl/cpu_8bit.sv
// ============================================================================
// cpu_8bit : accumulator CPU with a 32x8 shared memory loaded over an 8N1 UART
// Revision : 1.0
// ============================================================================
`default_nettype none

module cpu_8bit #(
  parameter int Baudrate = 10417
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       RX,
  output logic       FE,
  output logic [7:0] Instruction,
  output logic [7:0] Acc,
  output logic [7:0] Mem,
  output logic [4:0] Program_counter
);

  localparam int CNT_W = (Baudrate > 2) ? $clog2(Baudrate) : 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(Baudrate / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(Baudrate - 1);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_st_t;
  typedef enum logic [1:0] {S_LOAD, S_FETCH, S_EXEC, S_HALT} cpu_st_t;

  // RX synchronizer and edge history
  logic rx_meta_q, rx_meta_d;
  logic rx_sync_q, rx_sync_d;
  logic rx_prev_q, rx_prev_d;

  // UART receiver
  uart_st_t         uart_st_q, uart_st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             fe_q, fe_d;
  logic             byte_valid;

  // Loader
  logic       load_prev_q, load_prev_d;
  logic [4:0] wptr_q, wptr_d;
  logic [4:0] wptr_base;

  // Memory
  logic [7:0] mem_q [32];
  logic       mem_we;
  logic [4:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rd;

  // Control
  cpu_st_t    cpu_st_q, cpu_st_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] opcode;
  logic [4:0] addr;

  assign opcode = ir_q[7:5];
  assign addr   = ir_q[4:0];
  assign mem_rd = mem_q[addr];

  always_comb begin
    rx_meta_d   = RX;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    load_prev_d = Load;
  end

  always_comb begin
    uart_st_d  = uart_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    fe_d       = fe_q;
    byte_valid = 1'b0;
    unique case (uart_st_q)
      U_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          uart_st_d = U_START;
          cnt_d     = '0;
        end
      end
      U_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_d     = '0;
          uart_st_d = rx_sync_q ? U_IDLE : U_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) uart_st_d = U_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      U_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          uart_st_d = U_IDLE;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
            fe_d       = 1'b0;
          end else begin
            fe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: uart_st_d = U_IDLE;
    endcase
  end

  // A byte landing on the same edge as the Load rise goes to address 0.
  always_comb begin
    wptr_base = (Load && !load_prev_q) ? 5'd0 : wptr_q;
    wptr_d    = wptr_base;
    mem_we    = 1'b0;
    mem_waddr = wptr_base;
    mem_wdata = shift_q;
    if (Load) begin
      if (byte_valid) begin
        mem_we = 1'b1;
        wptr_d = wptr_base + 5'd1;
      end
    end else if (cpu_st_q == S_EXEC && opcode == OP_STO) begin
      mem_we    = 1'b1;
      mem_waddr = addr;
      mem_wdata = acc_q;
    end
  end

  always_comb begin
    cpu_st_d = cpu_st_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    acc_d    = acc_q;
    if (Load) begin
      cpu_st_d = S_LOAD;
      pc_d     = '0;
      ir_d     = '0;
    end else begin
      unique case (cpu_st_q)
        S_LOAD: cpu_st_d = S_FETCH;
        S_FETCH: begin
          ir_d     = mem_q[pc_q];
          pc_d     = pc_q + 5'd1;
          cpu_st_d = S_EXEC;
        end
        S_EXEC: begin
          cpu_st_d = S_FETCH;
          unique case (opcode)
            OP_HLT: cpu_st_d = S_HALT;
            OP_SKZ: if (acc_q == 8'd0) pc_d = pc_q + 5'd1;
            OP_ADD: acc_d = acc_q + mem_rd;
            OP_AND: acc_d = acc_q & mem_rd;
            OP_XOR: acc_d = acc_q ^ mem_rd;
            OP_LDA: acc_d = mem_rd;
            OP_STO: ;
            OP_JMP: pc_d = addr;
          endcase
        end
        S_HALT: ;
        default: cpu_st_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      uart_st_q   <= U_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      fe_q        <= 1'b0;
      load_prev_q <= 1'b0;
      wptr_q      <= '0;
      cpu_st_q    <= S_HALT;
      pc_q        <= '0;
      ir_q        <= '0;
      acc_q       <= '0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      uart_st_q   <= uart_st_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      fe_q        <= fe_d;
      load_prev_q <= load_prev_d;
      wptr_q      <= wptr_d;
      cpu_st_q    <= cpu_st_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      acc_q       <= acc_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign FE              = fe_q;
  assign Instruction     = ir_q;
  assign Acc             = acc_q;
  assign Mem             = mem_rd;
  assign Program_counter = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_8bit.sv
// ============================================================================
// tb_cpu_8bit : UART-loaded programs checked against an instruction-level model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_cpu_8bit;

  localparam int BAUD      = 24;
  localparam int MAX_STEPS = 60;
  localparam int RUN_WAIT  = 2 * MAX_STEPS + 20;

  typedef logic [7:0] mem_t [32];

  logic       clk = 1'b0;
  logic       reset, load, rx;
  logic       fe;
  logic [7:0] instr, acc, mem;
  logic [4:0] pc;

  cpu_8bit #(.Baudrate(BAUD)) dut (
    .Clk(clk), .Reset(reset), .Load(load), .RX(rx),
    .FE(fe), .Instruction(instr), .Acc(acc), .Mem(mem), .Program_counter(pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  mem_t       m_mem;
  logic [7:0] m_acc;
  int         m_wptr;
  logic       m_fe;
  logic [7:0] prog[$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Instruction-level interpreter of the ISA.
  task automatic sim_prog(input mem_t mi, input logic [7:0] ai, output mem_t mo,
                          output logic [7:0] ao, output logic [4:0] po,
                          output logic [7:0] io, output bit halted);
    mem_t m;
    logic [7:0] a_r, ir;
    logic [4:0] p, a;
    m = mi; a_r = ai; p = 5'd0; ir = 8'd0; halted = 1'b0;
    for (int s = 0; s < MAX_STEPS && !halted; s++) begin
      ir = m[p];
      p  = p + 5'd1;
      a  = ir[4:0];
      case (ir[7:5])
        3'd0: halted = 1'b1;
        3'd1: if (a_r == 8'd0) p = p + 5'd1;
        3'd2: a_r = a_r + m[a];
        3'd3: a_r = a_r & m[a];
        3'd4: a_r = a_r ^ m[a];
        3'd5: a_r = m[a];
        3'd6: m[a] = a_r;
        default: p = a;
      endcase
    end
    mo = m; ao = a_r; po = p; io = ir;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_acc = 8'h00; m_wptr = 0; m_fe = 1'b0;
  endtask

  task automatic raise_load();
    if (!load) begin
      @(negedge clk);
      load   = 1'b1;
      m_wptr = 0;
    end
    repeat (2) @(negedge clk);
    check_value("load_ir", instr, 8'h00);
    check_value("load_pc", pc, 5'd0);
  endtask

  task automatic load_prog();
    raise_load();
    foreach (prog[i]) begin
      send_byte(prog[i], 1'b1);
      m_mem[m_wptr] = prog[i];
      m_wptr = (m_wptr + 1) % 32;
      m_fe = 1'b0;
    end
  endtask

  task automatic run_and_check(input string tag);
    mem_t mo;
    logic [7:0] ao, io;
    logic [4:0] po;
    bit h;
    sim_prog(m_mem, m_acc, mo, ao, po, io, h);
    @(negedge clk);
    load = 1'b0;
    repeat (RUN_WAIT) @(negedge clk);
    m_mem = mo; m_acc = ao;
    check_value({tag, "_acc"}, acc, ao);
    check_value({tag, "_pc"}, pc, po);
    check_value({tag, "_ir"}, instr, io);
    check_value({tag, "_mem"}, mem, mo[io[4:0]]);
    check_value({tag, "_fe"}, fe, m_fe);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_t       trial, tmo;
    logic [7:0] tao, tio;
    logic [4:0] tpo;
    bit         th;
    int         len;
    logic [7:0] b;

    reset = 1'b1; load = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    check_value("rst_acc", acc, 8'h00);
    check_value("rst_pc", pc, 5'd0);
    check_value("rst_ir", instr, 8'h00);
    check_value("rst_mem", mem, 8'h00);
    check_value("rst_fe", fe, 1'b0);
    do_reset();

    // STO overwrites the program's own first word, JMP skips a word
    prog = {8'hC0, 8'h40, 8'hBB, 8'hE5, 8'hA0, 8'h00};
    load_prog();
    run_and_check("p1");
    check_value("p1_acc_c", acc, 8'h00);
    check_value("p1_pc_c", pc, 5'd6);
    check_value("p1_mem_c", mem, 8'h00);

    // 0x81 + 0x81 wraps to 0x02, stored at mem[5]
    do_reset();
    prog = {8'hA4, 8'h44, 8'hC5, 8'h00, 8'h81};
    load_prog();
    run_and_check("p2");
    check_value("p2_acc_c", acc, 8'h02);
    check_value("p2_pc_c", pc, 5'd4);
    prog = {8'hA5, 8'h00};
    load_prog();
    run_and_check("p2b");
    check_value("p2b_mem5", acc, 8'h02);

    // SKZ with Acc==0 skips the JMP
    do_reset();
    prog = {8'h20, 8'hE4, 8'hA5, 8'h00, 8'h00, 8'h7F};
    load_prog();
    run_and_check("p3");
    check_value("p3_acc_c", acc, 8'h7F);
    check_value("p3_pc_c", pc, 5'd4);
    check_value("p3_ir_c", instr, 8'h00);

    // Framing error: byte dropped, next good byte takes the same address
    do_reset();
    raise_load();
    prog = {8'hA1};
    load_prog();
    send_byte(8'h55, 1'b0);
    m_fe = 1'b1;
    check_value("fe_set", fe, 1'b1);
    prog = {8'h3C, 8'h00};
    load_prog();
    check_value("fe_clr", fe, 1'b0);
    run_and_check("p4");

    // Reset during the data bits of a frame
    raise_load();
    send_byte(8'h55, 1'b0);
    m_fe = 1'b1;
    check_value("fe_set2", fe, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (BAUD * 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_value("rstf_acc", acc, 8'h00);
        check_value("rstf_pc", pc, 5'd0);
        check_value("rstf_ir", instr, 8'h00);
        check_value("rstf_mem", mem, 8'h00);
        check_value("rstf_fe", fe, 1'b0);
        reset = 1'b0;
      end
    join
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_acc = 8'h00; m_wptr = 0; m_fe = 1'b0;
    prog = {8'hA2, 8'h00, 8'h99};
    load_prog();
    run_and_check("p5");

    // Reset while executing an endless loop
    prog = {8'hA3, 8'hE0, 8'h00, 8'h77};
    load_prog();
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    check_value("loop_acc", acc, 8'h77);
    reset = 1'b1;
    @(negedge clk);
    check_value("rste_acc", acc, 8'h00);
    check_value("rste_pc", pc, 5'd0);
    check_value("rste_ir", instr, 8'h00);
    check_value("rste_mem", mem, 8'h00);
    check_value("rste_fe", fe, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_acc = 8'h00; m_wptr = 0; m_fe = 1'b0;
    repeat (40) @(negedge clk);
    check_value("idle_pc", pc, 5'd0);
    check_value("idle_ir", instr, 8'h00);

    // 33 bytes wrap the write pointer; execution wraps PC 31->0
    do_reset();
    prog.delete();
    for (int i = 0; i < 32; i++) prog.push_back(8'h00);
    prog[2]  = 8'h5A;
    prog[30] = 8'hC0;
    prog[31] = 8'hA2;
    prog.push_back(8'hFE);
    load_prog();
    run_and_check("wrap");
    check_value("wrap_acc_c", acc, 8'h5A);
    check_value("wrap_pc_c", pc, 5'd1);

    // Random programs; Acc and memory carry over between loads
    for (int t = 0; t < 8; t++) begin
      if (t == 4) do_reset();
      th = 1'b0;
      for (int tries = 0; tries < 30 && !th; tries++) begin
        len = $urandom_range(3, 12);
        prog.delete();
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          if (b[7:5] == 3'd7 && $urandom_range(0, 1) == 0) b[7:5] = 3'd2;
          prog.push_back(b);
        end
        trial = m_mem;
        foreach (prog[i]) trial[i] = prog[i];
        sim_prog(trial, m_acc, tmo, tao, tpo, tio, th);
      end
      if (!th) prog = {8'h00};
      load_prog();
      run_and_check($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
